bram_port_arbiter: RTL and testbench

- Shares one BRAM port, 1-cycle synchronous read, among three requesters: req 0 = data access (MEM stage), req 1 = instruction fetch, req 2 = program loader/debug.
- Sits between the pipeline/loader and the BRAM wrapper.
- Handles per-requester valid/ready handshakes, priority with starvation protection, a loader lock mode, and return of read data to the owning requester.

---
 rtl/bram_arb_pkg.sv | 20 ++
 rtl/bram_port_arbiter_if.sv | 35 +++
 rtl/arb_pick3.sv | 53 +++++
 rtl/bram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the three-requester BRAM port arbiter.
// Requester indices, FSM state type and a lowest-set-bit helper.
package bram_arb_pkg;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned REQ_DMEM = 0;
  localparam int unsigned REQ_IMEM = 1;
  localparam int unsigned REQ_LDR  = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // One-hot of the lowest set bit; zero in, zero out.
  function automatic logic [NREQ-1:0] first_one(input logic [NREQ-1:0] m);
    return m & (~m + {{(NREQ-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side handshake bus plus BRAM-side port of the arbiter.
// slave = arbiter view, master = pipeline/loader/BRAM environment view.
interface bram_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  import bram_arb_pkg::*;

  localparam int unsigned BW = DW / 8;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*BW-1:0] req_we;
  logic [NREQ*DW-1:0] req_wdata;
  logic               ldr_lock;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      bram_addr;
  logic [BW-1:0]      bram_we;
  logic [DW-1:0]      bram_di;
  logic [DW-1:0]      bram_do;
  logic               locked;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, ldr_lock, bram_do,
    output req_ready, rsp_valid, rsp_rdata, bram_addr, bram_we, bram_di, locked
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, ldr_lock, bram_do,
    input  req_ready, rsp_valid, rsp_rdata, bram_addr, bram_we, bram_di, locked
  );

endinterface

// File: rtl/arb_pick3.sv
// Combinational winner select for three requesters; one-hot (or zero) grant.
// BRAM_ARB_RR_EN selects round-robin from a last-grant pointer instead of starvation priority.
module arb_pick3
  import bram_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
`ifdef BRAM_ARB_RR_EN
  input  logic [1:0]      last,
`else
  input  logic [NREQ-1:0] starved,
`endif
  input  logic            lock,
  output logic [NREQ-1:0] grant
);

`ifdef BRAM_ARB_RR_EN
  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (lock) begin
      grant[REQ_LDR] = valid[REQ_LDR];
    end else begin
      // Search starts one past the last winner and wraps.
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = (32'(last) + k) % NREQ;
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end
`else
  logic [NREQ-1:0] hungry;

  always_comb begin
    grant  = '0;
    hungry = valid & starved;
    if (lock) begin
      grant[REQ_LDR] = valid[REQ_LDR];
    end else if (|hungry) begin
      grant = first_one(hungry);
    end else begin
      grant = first_one(valid);
    end
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 1-cycle-read BRAM port among dmem, imem and loader requesters.
// Optional macro BRAM_ARB_RR_EN: round-robin arbitration instead of starvation priority.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned CNT_W        = 4
) (
  input logic                clk,
  input logic                rst,
  bram_port_arbiter_if.slave bus
);

  localparam int unsigned BW = DW / 8;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] accept;
  logic [NREQ-1:0] is_read;
  logic [NREQ-1:0] rd_pend_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   sel_addr;
  logic [BW-1:0]   sel_we;
  logic [DW-1:0]   sel_wdata;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a loader accept in LOCK with ldr_lock low still completes first
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (accept[REQ_LDR] && bus.ldr_lock) state_d = LOCK;
      LOCK:    if (!bus.ldr_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // FSM outputs
  always_comb begin
    grant         = rst ? '0 : pick;
    bus.req_ready = grant;
    bus.locked    = (state_q == LOCK);
  end

  assign accept = grant & bus.req_valid;

`ifdef BRAM_ARB_RR_EN
  logic [1:0] last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 2'(REQ_LDR);
    end else if (|accept) begin
      last_q <= accept[REQ_DMEM] ? 2'(REQ_DMEM) :
                accept[REQ_IMEM] ? 2'(REQ_IMEM) : 2'(REQ_LDR);
    end
  end

  arb_pick3 u_pick (
    .valid (bus.req_valid),
    .last  (last_q),
    .lock  (state_q == LOCK),
    .grant (pick)
  );
`else
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [NREQ-1:0]  starved;

  // Wait counters saturate at the limit, which is what marks a requester starved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || accept[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) starved[i] = (cnt_q[i] == CNT_W'(STARVE_LIMIT));
  end

  arb_pick3 u_pick (
    .valid   (bus.req_valid),
    .starved (starved),
    .lock    (state_q == LOCK),
    .grant   (pick)
  );
`endif

  // Granted requester's fields go straight to the BRAM in the grant cycle
  always_comb begin
    sel_addr  = addr_q;
    sel_we    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_we    = bus.req_we[i*BW +: BW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
    bus.bram_addr = sel_addr;
    bus.bram_we   = sel_we;
    bus.bram_di   = sel_wdata;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) is_read[i] = ~|bus.req_we[i*BW +: BW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      rd_pend_q <= '0;
    end else begin
      if (|accept) addr_q <= sel_addr;
      rd_pend_q <= accept & is_read;
    end
  end

  assign bus.rsp_valid = rd_pend_q;
  assign bus.rsp_rdata = (|rd_pend_q) ? bus.bram_do : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model with a shadow memory.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int          STARVE = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  bram_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (STARVE),
    .CNT_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM: byte-write, 1-cycle synchronous read, 64 words
  logic [31:0] mem [64];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.bram_we[b]) mem[bus.bram_addr[7:2]][b*8 +: 8] <= bus.bram_di[b*8 +: 8];
    bus.bram_do <= mem[bus.bram_addr[7:2]];
  end

  // Reference model state
  int          wait_cnt [3];
  bit          lock_m;
  int          last_m;
  int          pend_idx;
  logic [31:0] pend_data;
  logic [31:0] held_m;
  logic [31:0] ref_mem [64];

  int          exp_g;
  logic [2:0]  exp_ready, exp_rsp_v;
  logic [31:0] exp_rdata, exp_addr;
  logic [3:0]  exp_we;

  int vectors;
  int miscompares;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    lock_m   = 0;
    last_m   = 2;
    pend_idx = -1;
    pend_data = '0;
    held_m   = '0;
  endtask

  function automatic int model_pick(input logic [2:0] v);
    if (lock_m) return v[2] ? 2 : -1;
`ifdef BRAM_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (v[(last_m + k) % 3]) return (last_m + k) % 3;
`else
    for (int i = 0; i < 3; i++) if (v[i] && wait_cnt[i] >= STARVE) return i;
    for (int i = 0; i < 3; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic drive(input int i, input logic v, input logic [31:0] a,
                       input logic [3:0] we, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*32 +: 32]  = a;
    bus.req_we[i*4 +: 4]      = we;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  // Move to the sampling point of the current cycle and form the expectations
  task automatic settle();
    @(negedge clk);
    exp_g = model_pick(bus.req_valid);
    if (exp_g >= 0) begin
      exp_ready = 3'(1 << exp_g);
      exp_addr  = bus.req_addr[exp_g*32 +: 32];
      exp_we    = bus.req_we[exp_g*4 +: 4];
    end else begin
      exp_ready = 3'b000;
      exp_addr  = held_m;
      exp_we    = 4'h0;
    end
    exp_rsp_v = (pend_idx >= 0) ? 3'(1 << pend_idx) : 3'b000;
    exp_rdata = (pend_idx >= 0) ? pend_data : 32'h0;
  endtask

  // Clock edge: advance the model with this cycle's inputs, then release for new drive
  task automatic advance();
    int          g;
    logic [31:0] a;
    logic [3:0]  w;
    @(posedge clk);
    g = model_pick(bus.req_valid);
    for (int i = 0; i < 3; i++) begin
      if (!bus.req_valid[i] || g == i) wait_cnt[i] = 0;
      else if (wait_cnt[i] < STARVE) wait_cnt[i]++;
    end
    pend_idx = -1;
    if (g >= 0) begin
      a = bus.req_addr[g*32 +: 32];
      w = bus.req_we[g*4 +: 4];
      held_m = a;
      last_m = g;
      if (w == 4'h0) begin
        pend_idx  = g;
        pend_data = ref_mem[a[7:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (w[b]) ref_mem[a[7:2]][b*8 +: 8] = bus.req_wdata[g*32 + b*8 +: 8];
      end
    end
    if (!lock_m) begin
      if (g == 2 && bus.ldr_lock) lock_m = 1;
    end else if (!bus.ldr_lock) begin
      lock_m = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 4'h0, 32'h0);
    bus.ldr_lock = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    drive(0, 1'b1, 32'h24, 4'hF, 32'h1111_2222);
    drive(1, 1'b1, 32'h28, 4'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 000", bus.req_ready);
    end
    vectors++;
    if (bus.bram_we !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_bram_we: got %h want 0", bus.bram_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_inputs();
    settle();
    vectors++;
    if (bus.rsp_valid !== 3'b000 || bus.rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got %b/%h want 000/0", bus.rsp_valid, bus.rsp_rdata);
    end
    vectors++;
    if (bus.locked !== 1'b0 || bus.bram_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: locked %b addr %h want 0/0", bus.locked, bus.bram_addr);
    end
    advance();
  endtask

  task automatic test_pipelined_reads();
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h20, 4'h0, 32'h0);
    settle();
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL pipe_grant0: got %b want 001", bus.req_ready);
    end
    advance();
    drive(0, 1'b0, 32'h10, 4'h0, 32'h0);
    settle();
    vectors++;
    if (bus.req_ready !== 3'b010) begin
      miscompares++;
      $display("FAIL pipe_grant1: got %b want 010", bus.req_ready);
    end
    vectors++;
    if (bus.rsp_valid !== 3'b001 || bus.rsp_rdata !== 32'hA5A5_0000) begin
      miscompares++;
      $display("FAIL pipe_rsp0: got %b/%h want 001/a5a50000", bus.rsp_valid, bus.rsp_rdata);
    end
    advance();
    drive(1, 1'b0, 32'h20, 4'h0, 32'h0);
    settle();
    vectors++;
    if (bus.rsp_valid !== 3'b010 || bus.rsp_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL pipe_rsp1: got %b/%h want 010/12345678", bus.rsp_valid, bus.rsp_rdata);
    end
    advance();
  endtask

  task automatic test_starvation();
    int first  = -1;
    int second = -1;
    drive(0, 1'b1, 32'h14, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h18, 4'h0, 32'h0);
    for (int c = 0; c < 40; c++) begin
      settle();
      vectors++;
      if (bus.req_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL starve_grant c%0d: got %b want %b", c, bus.req_ready, exp_ready);
      end
      if (bus.req_ready[1] === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      advance();
    end
    vectors++;
    if (first != STARVE) begin
      miscompares++;
      $display("FAIL starve_first: req1 granted at cycle %0d want %0d", first, STARVE);
    end
    vectors++;
    if (second != 2 * STARVE + 1) begin
      miscompares++;
      $display("FAIL starve_second: req1 granted at cycle %0d want %0d", second, 2 * STARVE + 1);
    end
    clear_inputs();
    settle();
    advance();
  endtask

  task automatic test_lock();
    drive(2, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF);
    bus.ldr_lock = 1'b1;
    settle();
    vectors++;
    if (bus.req_ready !== 3'b100 || bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_enter: ready %b locked %b want 100/0", bus.req_ready, bus.locked);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
      drive(2, 1'b1, 32'h44 + 32'(4 * k), 4'hF, $urandom);
      bus.ldr_lock = (k != 2);  // last write overlaps the lock release
      settle();
      vectors++;
      if (bus.req_ready !== 3'b100 || bus.locked !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_hold k%0d: ready %b locked %b want 100/1", k, bus.req_ready,
                 bus.locked);
      end
      advance();
    end
    drive(2, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    vectors++;
    if (bus.req_ready !== 3'b001 || bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_exit: ready %b locked %b want 001/0", bus.req_ready, bus.locked);
    end
    advance();
    drive(0, 1'b0, 32'h40, 4'h0, 32'h0);
    settle();
    vectors++;
    if (bus.rsp_valid !== 3'b001 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL lock_readback: got %b/%h want 001/deadbeef", bus.rsp_valid, bus.rsp_rdata);
    end
    advance();
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    settle();
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL rmr_accept: got %b want 001", bus.req_ready);
    end
    advance();
    rst = 1'b1;
    model_reset();
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h20, 4'h0, 32'h0);
    drive(2, 1'b1, 32'h30, 4'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 3'b000 || bus.rsp_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL rmr_in_reset: ready %b rsp %b want 000/000", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    settle();
    vectors++;
    if (bus.rsp_valid !== 3'b000 || bus.locked !== 1'b0 || bus.req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL rmr_release: rsp %b locked %b ready %b want 000/0/001", bus.rsp_valid,
               bus.locked, bus.req_ready);
    end
    advance();
    clear_inputs();
    settle();
    advance();
  endtask

  task automatic test_idle();
    drive(1, 1'b1, 32'h1C, 4'h0, 32'h0);
    settle();
    advance();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      settle();
      vectors++;
      if (bus.bram_we !== 4'h0 || bus.bram_addr !== 32'h1C) begin
        miscompares++;
        $display("FAIL idle c%0d: we %h addr %h want 0/0000001c", c, bus.bram_we,
                 bus.bram_addr);
      end
      advance();
    end
  endtask

`ifdef BRAM_ARB_RR_EN
  task automatic test_round_robin();
    apply_reset();
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h20, 4'h0, 32'h0);
    drive(2, 1'b1, 32'h30, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      settle();
      vectors++;
      if (bus.req_ready !== 3'(1 << (c % 3))) begin
        miscompares++;
        $display("FAIL rr_order c%0d: got %b want %b", c, bus.req_ready, 3'(1 << (c % 3)));
      end
      advance();
    end
    clear_inputs();
    settle();
    advance();
  endtask
`endif

  task automatic test_random();
    int r;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      settle();
      vectors++;
      if (bus.req_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready);
      end
      vectors++;
      if (bus.rsp_valid !== exp_rsp_v || bus.rsp_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rnd_rsp c%0d: got %b/%h want %b/%h", c, bus.rsp_valid, bus.rsp_rdata,
                 exp_rsp_v, exp_rdata);
      end
      vectors++;
      if (bus.bram_addr !== exp_addr || bus.bram_we !== exp_we) begin
        miscompares++;
        $display("FAIL rnd_bram c%0d: got %h/%h want %h/%h", c, bus.bram_addr, bus.bram_we,
                 exp_addr, exp_we);
      end
      vectors++;
      if (bus.locked !== lock_m) begin
        miscompares++;
        $display("FAIL rnd_locked c%0d: got %b want %b", c, bus.locked, lock_m);
      end
      r = exp_g;
      advance();
      for (int i = 0; i < 3; i++) begin
        if (bus.req_valid[i] && r != i) begin
          // Waiting requesters hold their fields; occasionally one gives up
          if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0:       drive(i, 1'b1, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 4'h0, $urandom);
            1:       drive(i, 1'b1, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 4'hF, $urandom);
            default: drive(i, 1'b1, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 4'($urandom),
                           $urandom);
          endcase
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.ldr_lock = ($urandom_range(0, 3) == 0);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0100_0000 * 32'(i) + 32'(i);
      ref_mem[i] = 32'h0100_0000 * 32'(i) + 32'(i);
    end
    mem[4]     = 32'hA5A5_0000;
    ref_mem[4] = 32'hA5A5_0000;
    mem[8]     = 32'h1234_5678;
    ref_mem[8] = 32'h1234_5678;
    bus.bram_do = '0;

    test_reset();
    test_pipelined_reads();
`ifndef BRAM_ARB_RR_EN
    test_starvation();
`endif
    test_lock();
    test_reset_mid_read();
    test_idle();
`ifdef BRAM_ARB_RR_EN
    test_round_robin();
`endif
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
